mux2_arbiter: RTL
=================

# mux2_arbiter

Two-requester round-robin arbiter that shares one `mux2` datapath between two sources. It decides which source owns the mux and drives the mux select. It also registers the selected data with a valid flag for downstream logic such as display or register-file writes. A hold limit bounds how long one requester may own the datapath while the other is waiting.

## Interface
Parameters:
- `BIT`, 4, data width of each source and of `out`.
- `MAX_HOLD`, 8, maximum consecutive granted cycles while the other requester is waiting; legal range 1–255.

Ports:
- `clk`  input  1  single system clock, rising-edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req0`  input  1  level request from source 0; held high while it wants the datapath.
- `req1`  input  1  level request from source 1.
- `in0`  input  BIT  data from source 0.
- `in1`  input  BIT  data from source 1.
- `grant0`  output  1  source 0 owns the datapath; registered.
- `grant1`  output  1  source 1 owns the datapath; registered.
- `sel`  output  1  mux select: 0 = `in0`, 1 = `in1`; registered.
- `out`  output  BIT  registered selected data.
- `out_valid`  output  1  `out` carries granted data this cycle.

## Operation
- States:
  - IDLE: no grant.
  - G0: `grant0`=1, `sel`=0.
  - G1: `grant1`=1, `sel`=1.
- `grant0` and `grant1` are never high together.
- `last` records the most recently granted source. It resets to 1, so source 0 wins the first tie.
- `hold_cnt` is 8 bits and saturates at 255. It clears on every state change and increments each cycle the FSM stays in G0 or G1.
- IDLE transitions:
  - Only `req0` high: go to G0.
  - Only `req1` high: go to G1.
  - Both high: go to the source that is not `last`.
  - Neither high: stay in IDLE.
- G0 transitions (G1 is symmetric):
  - `req0` low and `req1` high: go to G1 directly, with no IDLE gap.
  - `req0` low and `req1` low: go to IDLE.
  - `req0` high, `req1` high and `hold_cnt` = MAX_HOLD−1: go to G1 (forced hand-off).
  - Otherwise stay in G0. A lone requester keeps the grant indefinitely.
- `last` updates on entry to G0 or G1.
- `sel` keeps its last value while in IDLE.
- Datapath, every cycle:
  - `out` <= `sel` ? `in1` : `in0`.
  - `out_valid` <= 1 when the current state is G0 or G1, else 0.
  - `out` is don't-care when `out_valid`=0, but it must still be a deterministic mux of the inputs.
- A requester that drops its request loses the grant. There is no pending-request memory.

## Timing
- Reset values while `rst` is high, applied immediately (asynchronous):
  - state = IDLE, `grant0`=0, `grant1`=0, `sel`=0, `out`=0, `out_valid`=0, `hold_cnt`=0, `last`=1.
- Grant latency: a request sampled at rising edge N produces a grant visible after edge N.
- Data latency: `out` and `out_valid` reflect the granted source one cycle after the grant appears.
- Release: a request dropping before edge N removes the grant after edge N. `out_valid` falls one edge later.
- Hand-off: `grant0` falls and `grant1` rises on the same edge. `out_valid` stays continuously high across the switch, and `out` changes source one cycle after `sel`.
- With both requests held continuously, each source is granted exactly MAX_HOLD consecutive cycles, alternating.
- MAX_HOLD=1: strict alternation every cycle while both requests are high.
- If `rst` asserts mid-grant, all outputs clear at once. After release, arbitration restarts with source 0 winning any tie.
- A request that rises and falls between two edges is not seen and is not granted.

## Test plan
- Reset: assert `rst` mid-cycle with `req0`=1 -> `grant0`, `grant1`, `sel`, `out_valid` and `out` are 0 immediately. After release, `grant0`=1 one edge later.
- Single requester: `req0`=1 for 20 cycles with `in0`=4'hA and `req1`=0 -> `grant0` high for 20 cycles, `out`=4'hA with `out_valid`=1 lagging by one cycle, no forced release.
- Tie from reset: `req0`=`req1`=1 held, MAX_HOLD=4 -> grant pattern 0,0,0,0,1,1,1,1,0,… and `out` alternates between `in0` and `in1` with one-cycle lag.
- Direct hand-off: `req0` owns the datapath with `req1` pending, then `req0` drops -> `grant1` rises on the same edge `grant0` falls, and `out_valid` shows no gap.
- Idle return and fairness: after G1 ends, drop both requests for 2 cycles, then raise both -> source 0 is granted (`last`=1).
- MAX_HOLD=1: both requests held for 6 cycles -> grants alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter that drives a shared mux select
// and registers the selected data with a valid flag.
module mux2_arbiter #(
    parameter int BIT      = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [BIT-1:0] in0,
    input  logic [BIT-1:0] in1,
    output logic           grant0,
    output logic           grant1,
    output logic           sel,
    output logic [BIT-1:0] out,
    output logic           out_valid
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_t;
    state_t state, nxt;
    logic last;
    logic [7:0] hold_cnt;
    logic limit;
    // >= rather than == so an owner that ran alone past the limit yields at once
    assign limit = hold_cnt >= 8'(MAX_HOLD - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (req0 && req1) ? (last ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
            G0:      nxt = !req0 ? (req1 ? G1 : IDLE) : (req1 && limit) ? G1 : G0;
            G1:      nxt = !req1 ? (req0 ? G0 : IDLE) : (req0 && limit) ? G0 : G1;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant0    <= 1'b0;
            grant1    <= 1'b0;
            sel       <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            last      <= 1'b1;
        end else begin
            state  <= nxt;
            grant0 <= nxt == G0;
            grant1 <= nxt == G1;
            if (nxt != state)
                hold_cnt <= '0;
            else if (state != IDLE && hold_cnt != 8'hFF)
                hold_cnt <= hold_cnt + 8'd1;
            if (nxt != state && nxt != IDLE) begin
                last <= nxt == G1;
                sel  <= nxt == G1;
            end
            out       <= sel ? in1 : in0;
            out_valid <= state != IDLE;
        end
    end
endmodule
